// File: rtl/sram_initiator_pkg.sv
// -----------------------------------------------------------------------------
// sram_initiator_pkg
// Purpose : shared definitions for the SRAM initiator slice: controller state
//           encoding, the two special byte-strobe values and the fixed SRAM
//           data width.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package sram_initiator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_FILL   = 2'd2
  } state_e;

  // WE of all zeros is a read cycle; all ones is a full-word write.
  localparam logic [3:0] WE_READ = 4'h0;
  localparam logic [3:0] WE_FULL = 4'hF;

  // Four byte strobes tie the data path to 32 bits.
  localparam int SRAM_DW = 32;

endpackage : sram_initiator_pkg

// File: rtl/sram_initiator_fill_addr_gen.sv
// -----------------------------------------------------------------------------
// sram_fill_addr_gen
// Purpose : address generator for the fill engine. Captures the first and last
//           address of an inclusive range and steps a pointer through it with
//           modulo-2^ADDRWIDTH wrap.
// Ports   : clk_i      clock
//           rst_ni     asynchronous active-low reset
//           load_i     capture base_i/last_i (pointer := base_i)
//           en_i       advance the pointer by one
//           base_i     first address of the range
//           last_i     last address of the range (inclusive)
//           ptr_o      address of the fill write in progress
//           is_last_o  ptr_o is the final address of the range
// -----------------------------------------------------------------------------
module sram_fill_addr_gen #(
  parameter int ADDRWIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic                 en_i,
  input  logic [ADDRWIDTH-1:0] base_i,
  input  logic [ADDRWIDTH-1:0] last_i,
  output logic [ADDRWIDTH-1:0] ptr_o,
  output logic                 is_last_o
);

  logic [ADDRWIDTH-1:0] ptr_q, ptr_d;
  logic [ADDRWIDTH-1:0] last_q, last_d;

  always_comb begin
    ptr_d  = ptr_q;
    last_d = last_q;
    if (load_i) begin
      ptr_d  = base_i;
      last_d = last_i;
    end else if (en_i) begin
      // Natural overflow of the adder gives the wrap through the top address.
      ptr_d = ptr_q + ADDRWIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q  <= '0;
      last_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      last_q <= last_d;
    end
  end

  assign ptr_o     = ptr_q;
  assign is_last_o = (ptr_q == last_q);

endmodule : sram_fill_addr_gen

// File: rtl/sram_initiator.sv
// -----------------------------------------------------------------------------
// sram_initiator
// Purpose : initiator-side controller for a byte-strobed single-port SRAM.
//           Turns a valid/ready request stream into SRAM cycles, returns read
//           data on a valid/ready response channel, and runs a fill engine
//           that writes one pattern over an inclusive (wrapping) address range.
// Ports   : CLK, RSTn                       clock, async active-low reset
//           REQ_VALID/READY/ADDR/WE/WDATA   request channel (WE==0 is a read)
//           RSP_VALID/READY/RDATA           read response channel
//           FILL_START/BASE/LAST/DATA       fill command
//           FILL_BUSY, FILL_DONE            fill status / completion pulse
//           CS, WE, ADDRESS, WDATA, RDATA   SRAM interface (outputs registered)
// -----------------------------------------------------------------------------
module sram_initiator
  import sram_initiator_pkg::*;
#(
  parameter int ADDRWIDTH = 16,
  parameter int DATAWIDTH = 32
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 REQ_VALID,
  output logic                 REQ_READY,
  input  logic [ADDRWIDTH-1:0] REQ_ADDR,
  input  logic [3:0]           REQ_WE,
  input  logic [DATAWIDTH-1:0] REQ_WDATA,
  output logic                 RSP_VALID,
  input  logic                 RSP_READY,
  output logic [DATAWIDTH-1:0] RSP_RDATA,
  input  logic                 FILL_START,
  input  logic [ADDRWIDTH-1:0] FILL_BASE,
  input  logic [ADDRWIDTH-1:0] FILL_LAST,
  input  logic [DATAWIDTH-1:0] FILL_DATA,
  output logic                 FILL_BUSY,
  output logic                 FILL_DONE,
  output logic                 CS,
  output logic [3:0]           WE,
  output logic [ADDRWIDTH-1:0] ADDRESS,
  output logic [DATAWIDTH-1:0] WDATA,
  input  logic [DATAWIDTH-1:0] RDATA
);

  state_e                 state_q, state_d;
  logic                   cs_q, cs_d;
  logic [3:0]             we_q, we_d;
  logic [ADDRWIDTH-1:0]   addr_q, addr_d;
  logic [DATAWIDTH-1:0]   wdata_q, wdata_d;
  logic                   done_q, done_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [DATAWIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic                   is_read_access;
  logic                   rsp_stall;
  logic                   req_accept;
  logic                   fill_accept;
  logic [ADDRWIDTH-1:0]   fill_ptr;
  logic                   fill_is_last;

  // A read ACCESS cycle is the only cycle in which RDATA is meaningful.
  assign is_read_access = (state_q == ST_ACCESS) && (we_q == WE_READ);
  assign rsp_stall      = rsp_valid_q && !RSP_READY;

  // Blocking a read during a read ACCESS guarantees the response register is
  // free (or being popped) whenever a new read result lands in it.
  assign REQ_READY   = !FILL_START && (state_q != ST_FILL) && !is_read_access && !rsp_stall;
  assign req_accept  = REQ_VALID && REQ_READY;
  assign fill_accept = FILL_START && (state_q != ST_FILL);

  sram_fill_addr_gen #(
    .ADDRWIDTH(ADDRWIDTH)
  ) u_fill_addr_gen (
    .clk_i     (CLK),
    .rst_ni    (RSTn),
    .load_i    (fill_accept),
    .en_i      (state_q == ST_FILL),
    .base_i    (FILL_BASE),
    .last_i    (FILL_LAST),
    .ptr_o     (fill_ptr),
    .is_last_o (fill_is_last)
  );

  always_comb begin
    state_d     = state_q;
    cs_d        = 1'b0;
    we_d        = WE_READ;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    done_d      = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;

    if (is_read_access) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = RDATA;
    end else if (RSP_READY) begin
      rsp_valid_d = 1'b0;
    end

    case (state_q)
      ST_FILL: begin
        if (fill_is_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          // WDATA already holds the pattern captured at fill acceptance.
          cs_d   = 1'b1;
          we_d   = WE_FULL;
          addr_d = fill_ptr + ADDRWIDTH'(1);
        end
      end
      default: begin
        if (fill_accept) begin
          state_d = ST_FILL;
          cs_d    = 1'b1;
          we_d    = WE_FULL;
          addr_d  = FILL_BASE;
          wdata_d = FILL_DATA;
        end else if (req_accept) begin
          state_d = ST_ACCESS;
          cs_d    = 1'b1;
          we_d    = REQ_WE;
          addr_d  = REQ_ADDR;
          wdata_d = REQ_WDATA;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= ST_IDLE;
      cs_q        <= 1'b0;
      we_q        <= WE_READ;
      addr_q      <= '0;
      wdata_q     <= '0;
      done_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cs_q        <= cs_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      done_q      <= done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign CS        = cs_q;
  assign WE        = we_q;
  assign ADDRESS   = addr_q;
  assign WDATA     = wdata_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_RDATA = rsp_rdata_q;
  assign FILL_BUSY = (state_q == ST_FILL);
  assign FILL_DONE = done_q;

endmodule : sram_initiator

// File: tb/tb_sram_initiator.sv
// -----------------------------------------------------------------------------
// tb_sram_initiator
// Purpose : directed self-checking bench for sram_initiator with a behavioural
//           byte-strobed SRAM. Unwritten words read as {16'hC0DE, address}.
// -----------------------------------------------------------------------------
module tb_sram_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        REQ_VALID, REQ_READY;
  logic [15:0] REQ_ADDR;
  logic [3:0]  REQ_WE;
  logic [31:0] REQ_WDATA;
  logic        RSP_VALID, RSP_READY;
  logic [31:0] RSP_RDATA;
  logic        FILL_START;
  logic [15:0] FILL_BASE, FILL_LAST;
  logic [31:0] FILL_DATA;
  logic        FILL_BUSY, FILL_DONE;
  logic        CS;
  logic [3:0]  WE;
  logic [15:0] ADDRESS;
  logic [31:0] WDATA;
  logic [31:0] rdata_model;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sram_initiator #(.ADDRWIDTH(16), .DATAWIDTH(32)) dut (
    .CLK(clk), .RSTn(rst_n),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ADDR(REQ_ADDR),
    .REQ_WE(REQ_WE), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
    .FILL_START(FILL_START), .FILL_BASE(FILL_BASE), .FILL_LAST(FILL_LAST),
    .FILL_DATA(FILL_DATA), .FILL_BUSY(FILL_BUSY), .FILL_DONE(FILL_DONE),
    .CS(CS), .WE(WE), .ADDRESS(ADDRESS), .WDATA(WDATA), .RDATA(rdata_model)
  );

  // ---------------- behavioural SRAM ----------------
  logic [31:0] mem [0:65535];
  bit          written [0:65535];
  int          fill_writes = 0;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  always_comb begin
    rdata_model = 32'hBAD0BAD0;
    if (CS && (WE == 4'h0))
      rdata_model = written[ADDRESS] ? mem[ADDRESS] : {16'hC0DE, ADDRESS};
  end

  always @(posedge clk) begin
    if (CS && (WE != 4'h0)) begin
      mem[ADDRESS]     <= merge(written[ADDRESS] ? mem[ADDRESS] : {16'hC0DE, ADDRESS}, WDATA, WE);
      written[ADDRESS] <= 1'b1;
      if ((WE == 4'hF) && FILL_BUSY) fill_writes <= fill_writes + 1;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input string tag, input logic [15:0] a, input logic [3:0] strb,
                          input logic [31:0] d);
    REQ_VALID = 1'b1; REQ_ADDR = a; REQ_WE = strb; REQ_WDATA = d;
    #1;
    chk({tag, ".ready"}, 32'(REQ_READY), 32'd1);
    tick;
    REQ_VALID = 1'b0;
    chk({tag, ".cs"}, 32'(CS), 32'd1);
    chk({tag, ".we"}, 32'(WE), 32'(strb));
    chk({tag, ".addr"}, 32'(ADDRESS), 32'(a));
    chk({tag, ".wdata"}, WDATA, d);
    tick;
    $display("write %s addr=%h we=%h data=%h", tag, a, strb, d);
  endtask

  task automatic do_read(input string tag, input logic [15:0] a, input logic [31:0] exp);
    REQ_VALID = 1'b1; REQ_ADDR = a; REQ_WE = 4'h0;
    #1;
    chk({tag, ".ready"}, 32'(REQ_READY), 32'd1);
    tick;
    REQ_VALID = 1'b0;
    chk({tag, ".cs"}, 32'(CS), 32'd1);
    chk({tag, ".addr"}, 32'(ADDRESS), 32'(a));
    chk({tag, ".ready_in_read"}, 32'(REQ_READY), 32'd0);
    tick;
    chk({tag, ".rsp_valid"}, 32'(RSP_VALID), 32'd1);
    chk({tag, ".rdata"}, RSP_RDATA, exp);
    tick;
    chk({tag, ".rsp_pop"}, 32'(RSP_VALID), 32'd0);
    $display("read  %s addr=%h data=%h", tag, a, RSP_RDATA);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [15:0] fexp [4];
    int          wr0;
    fexp = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

    rst_n = 1'b0;
    REQ_VALID = 0; REQ_ADDR = '0; REQ_WE = '0; REQ_WDATA = '0; RSP_READY = 1'b1;
    FILL_START = 0; FILL_BASE = '0; FILL_LAST = '0; FILL_DATA = '0;
    tick; tick;
    chk("rst.cs", 32'(CS), 32'd0);
    chk("rst.we", 32'(WE), 32'd0);
    chk("rst.rsp_valid", 32'(RSP_VALID), 32'd0);
    chk("rst.busy", 32'(FILL_BUSY), 32'd0);
    chk("rst.done", 32'(FILL_DONE), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("idle.ready", 32'(REQ_READY), 32'd1);
    $display("reset released");

    // write then read back, then byte-strobe merge
    do_write("w10", 16'h0010, 4'hF, 32'hDEADBEEF);
    chk("w10.cs_idle", 32'(CS), 32'd0);
    do_read("r10", 16'h0010, 32'hDEADBEEF);
    do_write("wstrb", 16'h0010, 4'b0101, 32'h11223344);
    do_read("rstrb", 16'h0010, 32'hDE22BE44);

    // back-to-back writes: no bubble between ACCESS cycles
    REQ_VALID = 1; REQ_ADDR = 16'h0020; REQ_WE = 4'hF; REQ_WDATA = 32'h01234567;
    tick;
    REQ_ADDR = 16'h0021; REQ_WDATA = 32'h89ABCDEF;
    #1;
    chk("b2b.ready", 32'(REQ_READY), 32'd1);
    tick;
    REQ_VALID = 0;
    chk("b2b.cs", 32'(CS), 32'd1);
    chk("b2b.addr", 32'(ADDRESS), 32'h0021);
    tick;
    $display("write b2b addr=0020,0021");
    do_read("r21", 16'h0021, 32'h89ABCDEF);

    // back-pressure on the response channel
    RSP_READY = 0;
    REQ_VALID = 1; REQ_ADDR = 16'h0010; REQ_WE = 4'h0;
    tick;
    REQ_ADDR = 16'h0020;
    tick;
    for (int i = 0; i < 5; i++) begin
      chk("bp.rsp_valid", 32'(RSP_VALID), 32'd1);
      chk("bp.rdata", RSP_RDATA, 32'hDE22BE44);
      chk("bp.ready", 32'(REQ_READY), 32'd0);
      chk("bp.cs", 32'(CS), 32'd0);
      tick;
    end
    RSP_READY = 1;
    #1;
    chk("bp.release_ready", 32'(REQ_READY), 32'd1);
    tick;
    REQ_VALID = 0;
    chk("bp.next_cs", 32'(CS), 32'd1);
    chk("bp.next_addr", 32'(ADDRESS), 32'h0020);
    chk("bp.popped", 32'(RSP_VALID), 32'd0);
    tick;
    chk("bp.next_rdata", RSP_RDATA, 32'h01234567);
    tick;
    $display("read  backpressure addr=0010 then 0020");

    // wrap fill with a coincident request
    wr0 = fill_writes;
    REQ_VALID = 1; REQ_ADDR = 16'h0002; REQ_WE = 4'h0;
    FILL_START = 1; FILL_BASE = 16'hFFFE; FILL_LAST = 16'h0001; FILL_DATA = 32'hA5A5A5A5;
    #1;
    chk("coll.ready", 32'(REQ_READY), 32'd0);
    tick;
    FILL_START = 0;
    for (int i = 0; i < 4; i++) begin
      chk("fill.busy", 32'(FILL_BUSY), 32'd1);
      chk("fill.cs", 32'(CS), 32'd1);
      chk("fill.we", 32'(WE), 32'hF);
      chk("fill.addr", 32'(ADDRESS), 32'(fexp[i]));
      chk("fill.wdata", WDATA, 32'hA5A5A5A5);
      chk("fill.done_early", 32'(FILL_DONE), 32'd0);
      chk("fill.ready", 32'(REQ_READY), 32'd0);
      tick;
    end
    chk("fill.done", 32'(FILL_DONE), 32'd1);
    chk("fill.busy_end", 32'(FILL_BUSY), 32'd0);
    chk("fill.cs_end", 32'(CS), 32'd0);
    chk("fill.ready_after", 32'(REQ_READY), 32'd1);
    tick;
    REQ_VALID = 0;
    chk("fill.done_pulse", 32'(FILL_DONE), 32'd0);
    chk("fill.rd_addr", 32'(ADDRESS), 32'h0002);
    tick;
    chk("fill.rd_valid", 32'(RSP_VALID), 32'd1);
    chk("fill.rd_0002", RSP_RDATA, 32'hC0DE0002);
    tick;
    chk("fill.count", 32'(fill_writes - wr0), 32'd4);
    $display("fill  base=FFFE last=0001 writes=%0d", fill_writes - wr0);
    do_read("rFFFF", 16'hFFFF, 32'hA5A5A5A5);
    do_read("r0000", 16'h0000, 32'hA5A5A5A5);
    do_read("rFFFD", 16'hFFFD, 32'hC0DEFFFD);

    // reset in the middle of a fill
    FILL_START = 1; FILL_BASE = 16'h0100; FILL_LAST = 16'h01FF; FILL_DATA = 32'h0;
    tick;
    FILL_START = 0;
    chk("abort.addr0", 32'(ADDRESS), 32'h0100);
    tick;
    chk("abort.addr1", 32'(ADDRESS), 32'h0101);
    rst_n = 0;
    #1;
    chk("abort.cs", 32'(CS), 32'd0);
    chk("abort.we", 32'(WE), 32'd0);
    chk("abort.address", 32'(ADDRESS), 32'd0);
    chk("abort.wdata", WDATA, 32'd0);
    chk("abort.busy", 32'(FILL_BUSY), 32'd0);
    tick; tick;
    chk("abort.done_in_rst", 32'(FILL_DONE), 32'd0);
    rst_n = 1;
    tick;
    chk("abort.done_after", 32'(FILL_DONE), 32'd0);
    chk("abort.busy_after", 32'(FILL_BUSY), 32'd0);
    chk("abort.cs_after", 32'(CS), 32'd0);
    $display("fill  aborted by reset");
    do_read("r0100", 16'h0100, 32'h00000000);
    do_read("r0101", 16'h0101, 32'hC0DE0101);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_sram_initiator
